// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream decoded instruction in, ALU operand bundle out, plus flush.
// The slave modport is the issue stage itself; master is whoever drives it.
interface alu_issue_stage_if #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
);
   logic               flush_i;
   logic               in_valid_i;
   logic               in_ready_o;
   logic [6:0]         opcode_i;
   logic [2:0]         funct3_i;
   logic [6:0]         funct7_i;
   logic [XLEN-1:0]    rs1_data_i;
   logic [XLEN-1:0]    rs2_data_i;
   logic [XLEN-1:0]    imm_i;
   logic [XLEN-1:0]    pc_i;
   logic [RADDR_W-1:0] rd_i;
   logic               out_valid_o;
   logic               out_ready_i;
   logic [3:0]         alu_op_o;
   logic [XLEN-1:0]    alu_a_o;
   logic [XLEN-1:0]    alu_b_o;
   logic [2:0]         funct3_o;
   logic [RADDR_W-1:0] rd_o;
   logic               illegal_o;

   modport slave (
      input  flush_i, in_valid_i, opcode_i, funct3_i, funct7_i,
             rs1_data_i, rs2_data_i, imm_i, pc_i, rd_i, out_ready_i,
      output in_ready_o, out_valid_o, alu_op_o, alu_a_o, alu_b_o,
             funct3_o, rd_o, illegal_o
   );

   modport master (
      output flush_i, in_valid_i, opcode_i, funct3_i, funct7_i,
             rs1_data_i, rs2_data_i, imm_i, pc_i, rd_i, out_ready_i,
      input  in_ready_o, out_valid_o, alu_op_o, alu_a_o, alu_b_o,
             funct3_o, rd_o, illegal_o
   );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes an RV32I instruction into ALU opcode/operands and
// holds it in an output register backed by one skid register for full throughput.
module alu_issue_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input logic             clk,
   input logic             rst,
   alu_issue_stage_if.slave bus
);

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_EQ   = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SRA  = 4'b0111,
      ALU_XOR  = 4'b1000,
      ALU_NOR  = 4'b1001,
      ALU_SUB  = 4'b1010,
      ALU_GE   = 4'b1100,
      ALU_GEU  = 4'b1101,
      ALU_SLT  = 4'b1110,
      ALU_SLTU = 4'b1111
   } aluOpE;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef struct packed {
      logic [3:0]         op;
      logic [XLEN-1:0]    a;
      logic [XLEN-1:0]    b;
      logic [2:0]         funct3;
      logic [RADDR_W-1:0] rd;
      logic               illegal;
   } entryT;

   // Shared OP/OP-IMM funct3 map; alt selects SUB over ADD and SRA over SRL.
   function automatic aluOpE aluFromF3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  aluFromF3 = alt ? ALU_SUB : ALU_ADD;
         3'b001:  aluFromF3 = ALU_SLL;
         3'b010:  aluFromF3 = ALU_SLT;
         3'b011:  aluFromF3 = ALU_SLTU;
         3'b100:  aluFromF3 = ALU_XOR;
         3'b101:  aluFromF3 = alt ? ALU_SRA : ALU_SRL;
         3'b110:  aluFromF3 = ALU_OR;
         default: aluFromF3 = ALU_AND;
      endcase
   endfunction

   entryT      decD;
   aluOpE      decOp;
   logic       decLegal;
   logic [XLEN-1:0] decA;
   logic [XLEN-1:0] decB;

   always_comb begin
      decOp    = ALU_AND;
      decA     = '0;
      decB     = '0;
      decLegal = 1'b1;
      case (bus.opcode_i)
         OPC_OP: begin
            decA     = bus.rs1_data_i;
            decB     = bus.rs2_data_i;
            decOp    = aluFromF3(bus.funct3_i, bus.funct7_i[5]);
            decLegal = (bus.funct7_i == F7_ZERO) ||
                       ((bus.funct7_i == F7_ALT) &&
                        ((bus.funct3_i == 3'b000) || (bus.funct3_i == 3'b101)));
         end
         OPC_OPIMM: begin
            decA  = bus.rs1_data_i;
            decB  = bus.imm_i;
            // Only shifts carry funct7; elsewhere those bits belong to the immediate.
            decOp = aluFromF3(bus.funct3_i, (bus.funct3_i == 3'b101) & bus.funct7_i[5]);
            if (bus.funct3_i == 3'b001)
               decLegal = (bus.funct7_i == F7_ZERO);
            else if (bus.funct3_i == 3'b101)
               decLegal = (bus.funct7_i == F7_ZERO) || (bus.funct7_i == F7_ALT);
         end
         OPC_LOAD, OPC_STORE: begin
            decA  = bus.rs1_data_i;
            decB  = bus.imm_i;
            decOp = ALU_ADD;
         end
         OPC_BRANCH: begin
            decA = bus.rs1_data_i;
            decB = bus.rs2_data_i;
            case (bus.funct3_i[2:1])
               2'b00:   decOp = ALU_SUB;
               2'b10:   decOp = ALU_SLT;
               2'b11:   decOp = ALU_SLTU;
               default: decLegal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            decB  = bus.imm_i;
            decOp = ALU_ADD;
         end
         OPC_AUIPC: begin
            decA  = bus.pc_i;
            decB  = bus.imm_i;
            decOp = ALU_ADD;
         end
         OPC_JAL, OPC_JALR: begin
            decA  = bus.pc_i;
            decB  = XLEN'(4);
            decOp = ALU_ADD;
         end
         default: decLegal = 1'b0;
      endcase

      decD.funct3  = bus.funct3_i;
      decD.rd      = bus.rd_i;
      decD.illegal = !decLegal;
      decD.op      = decLegal ? decOp : ALU_AND;
      decD.a       = decLegal ? decA  : '0;
      decD.b       = decLegal ? decB  : '0;
   end

   logic  outValid_q, outValid_d;
   logic  skidValid_q, skidValid_d;
   entryT out_q, out_d;
   entryT skid_q, skid_d;
   logic  inReady;
   logic  accept;
   logic  transfer;

   assign inReady  = !skidValid_q && !rst;
   assign accept   = bus.in_valid_i && inReady;
   assign transfer = outValid_q && bus.out_ready_i;

   // OUT refills from SKID first so ordering stays FIFO; flush drops everything.
   always_comb begin
      outValid_d  = outValid_q;
      skidValid_d = skidValid_q;
      out_d       = out_q;
      skid_d      = skid_q;
      if (bus.flush_i) begin
         outValid_d  = 1'b0;
         skidValid_d = 1'b0;
      end else if (!outValid_q || transfer) begin
         if (skidValid_q) begin
            out_d       = skid_q;
            outValid_d  = 1'b1;
            skidValid_d = 1'b0;
         end else if (accept) begin
            out_d      = decD;
            outValid_d = 1'b1;
         end else begin
            outValid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d      = decD;
         skidValid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outValid_q  <= 1'b0;
         skidValid_q <= 1'b0;
         out_q       <= '0;
         skid_q      <= '0;
      end else begin
         outValid_q  <= outValid_d;
         skidValid_q <= skidValid_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
      end
   end

   assign bus.in_ready_o  = inReady;
   assign bus.out_valid_o = outValid_q;
   assign bus.alu_op_o    = out_q.op;
   assign bus.alu_a_o     = out_q.a;
   assign bus.alu_b_o     = out_q.b;
   assign bus.funct3_o    = out_q.funct3;
   assign bus.rd_o        = out_q.rd;
   assign bus.illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode cases, backpressure ordering,
// flush and mid-stream reset, with hand-computed expectations.
module tb_alu_issue_stage;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] BADOPC = 7'b1111111;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   alu_issue_stage_if #(.XLEN(32), .RADDR_W(5)) bus ();

   alu_issue_stage #(.XLEN(32), .RADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [4:0] rd);
      bus.in_valid_i = 1'b1;
      bus.opcode_i   = opc;
      bus.funct3_i   = f3;
      bus.funct7_i   = f7;
      bus.rs1_data_i = rs1;
      bus.rs2_data_i = rs2;
      bus.imm_i      = imm;
      bus.pc_i       = pc;
      bus.rd_i       = rd;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst            = 1'b1;
      bus.flush_i    = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.out_ready_i = 1'b1;
      applyStimulus(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
      bus.in_valid_i = 1'b0;
      tick();
      tick();

      checkOutput("rst_in_ready",  bus.in_ready_o,  0);
      checkOutput("rst_out_valid", bus.out_valid_o, 0);
      checkOutput("rst_op",        bus.alu_op_o,    0);
      checkOutput("rst_a",         bus.alu_a_o,     0);
      checkOutput("rst_b",         bus.alu_b_o,     0);
      checkOutput("rst_funct3",    bus.funct3_o,    0);
      checkOutput("rst_rd",        bus.rd_o,        0);
      checkOutput("rst_illegal",   bus.illegal_o,   0);

      rst = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", bus.in_ready_o, 1);

      applyStimulus(OP, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3);
      tick();
      checkOutput("add_valid",   bus.out_valid_o, 1);
      checkOutput("add_op",      bus.alu_op_o,    4'b0010);
      checkOutput("add_a",       bus.alu_a_o,     32'd5);
      checkOutput("add_b",       bus.alu_b_o,     32'd7);
      checkOutput("add_rd",      bus.rd_o,        5'd3);
      checkOutput("add_illegal", bus.illegal_o,   0);

      applyStimulus(OP, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd4);
      tick();
      checkOutput("sra_op",     bus.alu_op_o, 4'b0111);
      checkOutput("sra_a",      bus.alu_a_o,  32'h8000_0000);
      checkOutput("sra_b",      bus.alu_b_o,  32'd4);
      checkOutput("sra_funct3", bus.funct3_o, 3'b101);

      applyStimulus(OPIMM, 3'b000, 7'b0100000, 32'd3, 32'd0, 32'd9, 32'd0, 5'd5);
      tick();
      checkOutput("addi_f7_op", bus.alu_op_o, 4'b0010);
      checkOutput("addi_f7_a",  bus.alu_a_o,  32'd3);
      checkOutput("addi_f7_b",  bus.alu_b_o,  32'd9);

      applyStimulus(AUIPC, 3'b000, 7'd0, 32'hDEAD, 32'hBEEF, 32'h2000, 32'h100, 5'd6);
      tick();
      checkOutput("auipc_op", bus.alu_op_o, 4'b0010);
      checkOutput("auipc_a",  bus.alu_a_o,  32'h100);
      checkOutput("auipc_b",  bus.alu_b_o,  32'h2000);

      applyStimulus(JAL, 3'b000, 7'd0, 32'h11, 32'h22, 32'h800, 32'h40, 5'd1);
      tick();
      checkOutput("jal_op", bus.alu_op_o, 4'b0010);
      checkOutput("jal_a",  bus.alu_a_o,  32'h40);
      checkOutput("jal_b",  bus.alu_b_o,  32'd4);

      applyStimulus(OP, 3'b000, 7'b0100000, 32'd9, 32'd2, 32'd0, 32'd0, 5'd7);
      tick();
      checkOutput("sub_op", bus.alu_op_o, 4'b1010);

      applyStimulus(BRANCH, 3'b101, 7'd0, 32'd1, 32'd2, 32'h10, 32'd0, 5'd0);
      tick();
      checkOutput("bge_op", bus.alu_op_o, 4'b1110);
      checkOutput("bge_a",  bus.alu_a_o,  32'd1);
      checkOutput("bge_b",  bus.alu_b_o,  32'd2);

      applyStimulus(LUI, 3'b000, 7'd0, 32'h77, 32'd0, 32'h1234_5000, 32'h200, 5'd8);
      tick();
      checkOutput("lui_a", bus.alu_a_o, 32'd0);
      checkOutput("lui_b", bus.alu_b_o, 32'h1234_5000);

      applyStimulus(OPIMM, 3'b001, 7'b0100000, 32'd3, 32'd0, 32'd1, 32'd0, 5'd9);
      tick();
      checkOutput("slli_f7_illegal", bus.illegal_o, 1);
      checkOutput("slli_f7_op",      bus.alu_op_o,  4'b0000);

      applyStimulus(OP, 3'b010, 7'b0100000, 32'd3, 32'd4, 32'd0, 32'd0, 5'd9);
      tick();
      checkOutput("slt_f7_illegal", bus.illegal_o, 1);

      applyStimulus(BADOPC, 3'b000, 7'd0, 32'h55, 32'h66, 32'h77, 32'h88, 5'd10);
      tick();
      checkOutput("badopc_valid",   bus.out_valid_o, 1);
      checkOutput("badopc_illegal", bus.illegal_o,   1);
      checkOutput("badopc_op",      bus.alu_op_o,    4'b0000);
      checkOutput("badopc_a",       bus.alu_a_o,     32'd0);
      checkOutput("badopc_b",       bus.alu_b_o,     32'd0);

      applyStimulus(BRANCH, 3'b010, 7'd0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd0);
      tick();
      checkOutput("br010_illegal", bus.illegal_o, 1);
      checkOutput("br010_a",       bus.alu_a_o,   32'd0);

      bus.in_valid_i = 1'b0;
      tick();
      checkOutput("drain_valid", bus.out_valid_o, 0);

      // Backpressure: I0..I3 tagged by rs1 = 0xA0+k.
      bus.out_ready_i = 1'b0;
      applyStimulus(OP, 3'b000, 7'd0, 32'hA0, 32'd1, 32'd0, 32'd0, 5'd0);
      tick();
      checkOutput("bp_i0_valid", bus.out_valid_o, 1);
      checkOutput("bp_i0_a",     bus.alu_a_o,     32'hA0);
      checkOutput("bp_ready1",   bus.in_ready_o,  1);
      applyStimulus(OP, 3'b000, 7'd0, 32'hA1, 32'd1, 32'd0, 32'd0, 5'd1);
      tick();
      checkOutput("bp_ready_drop", bus.in_ready_o, 0);
      checkOutput("bp_hold_a",     bus.alu_a_o,    32'hA0);
      applyStimulus(OP, 3'b000, 7'd0, 32'hA2, 32'd1, 32'd0, 32'd0, 5'd2);
      tick();
      checkOutput("bp_ready_low",  bus.in_ready_o, 0);
      checkOutput("bp_hold_a2",    bus.alu_a_o,    32'hA0);
      checkOutput("bp_hold_rd",    bus.rd_o,       5'd0);
      bus.out_ready_i = 1'b1;
      tick();
      checkOutput("bp_i1_a",     bus.alu_a_o,    32'hA1);
      checkOutput("bp_i1_rd",    bus.rd_o,       5'd1);
      checkOutput("bp_ready_up", bus.in_ready_o, 1);
      tick();
      checkOutput("bp_i2_a", bus.alu_a_o, 32'hA2);
      applyStimulus(OP, 3'b000, 7'd0, 32'hA3, 32'd1, 32'd0, 32'd0, 5'd3);
      tick();
      checkOutput("bp_i3_a",     bus.alu_a_o,     32'hA3);
      checkOutput("bp_i3_valid", bus.out_valid_o, 1);
      bus.in_valid_i = 1'b0;
      tick();
      checkOutput("bp_empty", bus.out_valid_o, 0);

      // Flush with OUT and SKID both full and a new instruction offered.
      bus.out_ready_i = 1'b0;
      applyStimulus(OP, 3'b000, 7'd0, 32'h11, 32'd0, 32'd0, 32'd0, 5'd0);
      tick();
      applyStimulus(OP, 3'b000, 7'd0, 32'h22, 32'd0, 32'd0, 32'd0, 5'd0);
      tick();
      checkOutput("fl_full_ready", bus.in_ready_o, 0);
      applyStimulus(OP, 3'b000, 7'd0, 32'h33, 32'd0, 32'd0, 32'd0, 5'd0);
      bus.flush_i = 1'b1;
      tick();
      checkOutput("fl_valid", bus.out_valid_o, 0);
      checkOutput("fl_ready", bus.in_ready_o,  1);
      // Flush with room available still drops the same-cycle accept.
      applyStimulus(OP, 3'b000, 7'd0, 32'h44, 32'd0, 32'd0, 32'd0, 5'd0);
      tick();
      checkOutput("fl_drop_accept", bus.out_valid_o, 0);
      bus.flush_i     = 1'b0;
      bus.out_ready_i = 1'b1;
      applyStimulus(OP, 3'b000, 7'd0, 32'h55, 32'd0, 32'd0, 32'd0, 5'd0);
      tick();
      checkOutput("fl_next_valid", bus.out_valid_o, 1);
      checkOutput("fl_next_a",     bus.alu_a_o,     32'h55);
      bus.in_valid_i = 1'b0;
      tick();
      checkOutput("fl_no_ghost", bus.out_valid_o, 0);

      // Reset mid-stream with both slots occupied.
      bus.out_ready_i = 1'b0;
      applyStimulus(OP, 3'b111, 7'd0, 32'h66, 32'h1, 32'd0, 32'd0, 5'd12);
      tick();
      applyStimulus(OP, 3'b110, 7'd0, 32'h77, 32'h1, 32'd0, 32'd0, 5'd13);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("mrst_valid",    bus.out_valid_o, 0);
      checkOutput("mrst_op",       bus.alu_op_o,    0);
      checkOutput("mrst_a",        bus.alu_a_o,     0);
      checkOutput("mrst_b",        bus.alu_b_o,     0);
      checkOutput("mrst_funct3",   bus.funct3_o,    0);
      checkOutput("mrst_rd",       bus.rd_o,        0);
      checkOutput("mrst_illegal",  bus.illegal_o,   0);
      checkOutput("mrst_in_ready", bus.in_ready_o,  0);
      rst             = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      #1;
      checkOutput("mrst_ready_after", bus.in_ready_o, 1);
      tick();
      checkOutput("mrst_no_skid", bus.out_valid_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
